// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB pipeline register feeding a 32-entry integer register file.
// Optional macro RF_BYPASS_EN enables write-first bypass of the committing value onto rd0/rd1.
module wb_regfile #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREG   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid_in,
  input  logic              mem_we_in,
  input  logic [ADDR_W-1:0] mem_rd_in,
  input  logic [DATA_W-1:0] mem_wd_in,
  input  logic [ADDR_W-1:0] ra0,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra_dbg,
  output logic [DATA_W-1:0] rd0,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd_dbg,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_wd,
  output logic [31:0]       retire_cnt
);

  logic              wb_valid_reg;
  logic              wb_we_reg;
  logic [ADDR_W-1:0] wb_rd_reg;
  logic [DATA_W-1:0] wb_wd_reg;
  logic [31:0]       retire_cnt_reg;
  logic [DATA_W-1:0] regs_reg [NREG];
  logic              retire;
  logic              commit;
  logic [DATA_W-1:0] store0;
  logic [DATA_W-1:0] store1;

  // An instruction retires on the first edge it sits in MEM/WB unstalled.
  assign retire = wb_valid_reg & ~stall & ~rst;
  assign commit = retire & wb_we_reg & (wb_rd_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_rd_reg    <= '0;
      wb_wd_reg    <= '0;
    end else if (flush) begin
      wb_valid_reg <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_rd_reg    <= '0;
      wb_wd_reg    <= '0;
    end else if (!stall) begin
      wb_valid_reg <= mem_valid_in;
      wb_we_reg    <= mem_we_in & mem_valid_in;
      wb_rd_reg    <= mem_rd_in;
      wb_wd_reg    <= mem_wd_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_reg <= '0;
    end else if (retire) begin
      retire_cnt_reg <= retire_cnt_reg + 32'd1;
    end
  end

  // Entry 0 is never written because commit excludes wb_rd == 0.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (commit && (wb_rd_reg == ADDR_W'(gi))) begin
          regs_reg[gi] <= wb_wd_reg;
        end
      end
    end
  endgenerate

  assign store0 = (ra0 == '0) ? '0 : regs_reg[ra0];
  assign store1 = (ra1 == '0) ? '0 : regs_reg[ra1];
  assign rd_dbg = (ra_dbg == '0) ? '0 : regs_reg[ra_dbg];

`ifdef RF_BYPASS_EN
  assign rd0 = (commit && (ra0 == wb_rd_reg)) ? wb_wd_reg : store0;
  assign rd1 = (commit && (ra1 == wb_rd_reg)) ? wb_wd_reg : store1;
`else
  assign rd0 = store0;
  assign rd1 = store1;
`endif

  assign wb_valid   = wb_valid_reg;
  assign wb_we      = wb_we_reg;
  assign wb_rd      = wb_rd_reg;
  assign wb_wd      = wb_wd_reg;
  assign retire_cnt = retire_cnt_reg;

endmodule
